id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register plus RAW-hazard interlock for the 5-stage RISC-V pipeline. It captures decoded instructions from ID and presents them to EX, and produces the `ex_rs1_o`/`ex_rs2_o` register numbers that the downstream forwarding unit compares against MEM/WB. Operands are forwarded only from MEM/WB, so this block stalls ID for any source dependence on an instruction still in EX or MEM, inserting bubbles. It also inserts bubbles on EX-resolved flushes and counts stall cycles.

## Interface
- `XLEN`, 32, datapath width
- `CNT_W`, 32, stall counter width
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `hold_i`  in  1  global freeze (memory wait); ID/EX and counter hold
- `flush_i`  in  1  taken branch/jump resolved in EX; squash ID
- `id_valid_i`  in  1  ID holds a real instruction
- `id_pc_i`  in  XLEN  instruction PC
- `id_rs1_i`, `id_rs2_i`, `id_rd_i`  in  5 each  register numbers
- `id_rs1_used_i`, `id_rs2_used_i`  in  1 each  source actually read
- `id_rs1_data_i`, `id_rs2_data_i`, `id_imm_i`  in  XLEN each  operands, immediate
- `id_ctrl_i`  in  12  packed control word `EX_CTRL_W`, layout in package
- `ex_mem_rd_i`  in  5  destination of the instruction in MEM
- `ex_mem_reg_write_i`  in  1  the MEM instruction writes `rd`
- `stall_o`  out  1  combinational; hold PC and IF/ID this cycle
- `ex_valid_o`, `ex_pc_o`, `ex_rs1_o`, `ex_rs2_o`, `ex_rd_o`, `ex_rs1_data_o`, `ex_rs2_data_o`, `ex_imm_o`, `ex_ctrl_o`  out  registered copies of the `id_*` fields
- `stall_cnt_o`  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- `dep(rd)`: `rd != 0` and ((`id_rs1_used_i` and `id_rs1_i == rd`) or (`id_rs2_used_i` and `id_rs2_i == rd`)).
- `hz`: `id_valid_i` and ((`ex_valid_o` and `ex_ctrl_o.reg_write` and `dep(ex_rd_o)`) or (`ex_mem_reg_write_i` and `dep(ex_mem_rd_i)`)).
- `stall_o = hz and not flush_i`. It is independent of `hold_i`; upstream ORs the two.
- Per edge, in priority order:
  - `hold_i`: all registers and the counter keep their values.
  - `flush_i`: load a bubble.
  - `hz`: load a bubble; `stall_cnt_o` += 1, saturating at all-ones.
  - otherwise: load the `id_*` fields. `ex_valid_o = id_valid_i`.
- Bubble: `ex_valid_o = 0`, `ex_ctrl_o = 0`, and every register-number and data field = 0. A bubble can never match in forwarding or in the hazard check.
- A distance-1 dependence gives 2 stall cycles. A distance-2 dependence gives 1. Distance ≥3 is covered by MEM/WB forwarding or the register-file write-first read, which is outside this block.

## Timing
- Reset, asynchronous while `rst_n` low: every `ex_*` output 0, `stall_cnt_o` 0. `stall_o` is then driven only by the ID and EX/MEM inputs, because `ex_valid_o` is 0.
- Deasserting reset mid-instruction discards that instruction. Upstream re-fetches it.
- ID-to-EX latency is 1 cycle when no hazard, flush or hold is present.
- `stall_o` has a purely combinational path from the `id_*`, `ex_mem_*` and `flush_i` inputs. It has no path from `hold_i`.
- `flush_i` and `hz` in the same cycle: a single bubble, `stall_o = 0`, counter unchanged.
- `hold_i` together with `flush_i` or `hz`: `hold_i` wins. The flush or stall takes effect on the first edge after `hold_i` drops, if it is still asserted then.

## Structure
- Shared package `riscv_pipe_pkg` holds:
  - `EX_CTRL_W = 12`
  - control-word bit indices: `reg_write`, `mem_read`, `mem_write`, `mem_to_reg`, `alu_src`, `branch`, `alu_op[1:0]`, `funct7_b5`, `funct3[2:0]`
  - `BUBBLE_CTRL = 0`
- Sub-module `hazard_detect` (combinational) computes `hz` from the ID sources and the two producer `rd`/write-enable pairs.
- The top level holds the register bank, the priority mux and the counter.

## Test plan
- Reset: pulse `rst_n` low mid-cycle while `ex_valid_o = 1`, `ex_rd_o = 7` -> all outputs read 0 immediately, without waiting for a clock edge.
- `add x5,x1,x2` followed by `add x6,x5,x3` -> `stall_o = 1` for 2 cycles, 2 bubbles enter EX, then `ex_rs1_o = 5` with `ex_valid_o = 1`, and `stall_cnt_o = 2`.
- Producer in EX/MEM only (`ex_mem_rd_i = 9`, write enabled) and ID reads x9 -> exactly 1 stall cycle, `stall_cnt_o` += 1.
- No false stalls:
  - producer `rd = 0` -> no stall.
  - ID `rs2 = 5` with `rs2_used = 0` (`lui`) against EX `rd = 5` -> no stall.
  - EX bubble -> no stall.
- `flush_i = 1` and hazard in the same cycle -> `stall_o = 0`, next cycle `ex_valid_o = 0`, `ex_ctrl_o = 0`, counter unchanged.
- `hold_i = 1` for 3 cycles with a hazard present -> `ex_*` and `stall_cnt_o` frozen. After release the stall sequence proceeds normally. With `stall_cnt_o` preset at all-ones, a further stall keeps it at all-ones.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types and control-word layout for the ID/EX pipeline boundary.
// The control word travels as a flat vector; the struct documents its packing.
package riscv_pipe_pkg;

    localparam int EX_CTRL_W = 12;

    localparam int CTRL_REG_WRITE  = 11;
    localparam int CTRL_MEM_READ   = 10;
    localparam int CTRL_MEM_WRITE  = 9;
    localparam int CTRL_MEM_TO_REG = 8;
    localparam int CTRL_ALU_SRC    = 7;
    localparam int CTRL_BRANCH     = 6;
    localparam int CTRL_ALU_OP_HI  = 5;
    localparam int CTRL_ALU_OP_LO  = 4;
    localparam int CTRL_FUNCT7_B5  = 3;
    localparam int CTRL_FUNCT3_HI  = 2;
    localparam int CTRL_FUNCT3_LO  = 0;

    localparam logic [EX_CTRL_W-1:0] BUBBLE_CTRL = '0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       funct7_b5;
        logic [2:0] funct3;
    } ex_ctrl_t;

    // x0 never carries a dependence
    function automatic logic reads_reg(
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       rs1_used,
        input logic [4:0] rs2,
        input logic       rs2_used
    );
        return (rd != 5'd0) &&
               ((rs1_used && (rs1 == rd)) ||
                (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// RAW interlock: flags an ID source that depends on a producer still in EX
// or MEM, since operands are only forwarded from MEM/WB.
module hazard_detect
    import riscv_pipe_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic       ex_valid,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_rd,
    output logic       hz
);

    logic ex_dep;
    logic mem_dep;

    assign ex_dep = ex_valid && ex_reg_write &&
                    reads_reg(ex_rd, id_rs1, id_rs1_used,
                              id_rs2, id_rs2_used);

    assign mem_dep = mem_reg_write &&
                     reads_reg(mem_rd, id_rs1, id_rs1_used,
                               id_rs2, id_rs2_used);

    assign hz = id_valid && (ex_dep || mem_dep);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW interlock, flush bubbles and a
// saturating counter of hazard-stall cycles.
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold_i,
    input  logic                 flush_i,
    input  logic                 id_valid_i,
    input  logic [XLEN-1:0]      id_pc_i,
    input  logic [4:0]           id_rs1_i,
    input  logic [4:0]           id_rs2_i,
    input  logic [4:0]           id_rd_i,
    input  logic                 id_rs1_used_i,
    input  logic                 id_rs2_used_i,
    input  logic [XLEN-1:0]      id_rs1_data_i,
    input  logic [XLEN-1:0]      id_rs2_data_i,
    input  logic [XLEN-1:0]      id_imm_i,
    input  logic [EX_CTRL_W-1:0] id_ctrl_i,
    input  logic [4:0]           ex_mem_rd_i,
    input  logic                 ex_mem_reg_write_i,
    output logic                 stall_o,
    output logic                 ex_valid_o,
    output logic [XLEN-1:0]      ex_pc_o,
    output logic [4:0]           ex_rs1_o,
    output logic [4:0]           ex_rs2_o,
    output logic [4:0]           ex_rd_o,
    output logic [XLEN-1:0]      ex_rs1_data_o,
    output logic [XLEN-1:0]      ex_rs2_data_o,
    output logic [XLEN-1:0]      ex_imm_o,
    output logic [EX_CTRL_W-1:0] ex_ctrl_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    logic hz;
    logic bubble;
    logic cnt_full;

    hazard_detect u_hazard (
        .id_valid      (id_valid_i),
        .id_rs1        (id_rs1_i),
        .id_rs2        (id_rs2_i),
        .id_rs1_used   (id_rs1_used_i),
        .id_rs2_used   (id_rs2_used_i),
        .ex_valid      (ex_valid_o),
        .ex_reg_write  (ex_ctrl_o[CTRL_REG_WRITE]),
        .ex_rd         (ex_rd_o),
        .mem_reg_write (ex_mem_reg_write_i),
        .mem_rd        (ex_mem_rd_i),
        .hz            (hz)
    );

    // hold_i is deliberately absent here; upstream ORs it in
    assign stall_o  = hz && !flush_i;
    assign bubble   = flush_i || hz;
    assign cnt_full = (stall_cnt_o == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o    <= 1'b0;
            ex_pc_o       <= '0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_ctrl_o     <= BUBBLE_CTRL;
        end else if (!hold_i) begin
            if (bubble) begin
                ex_valid_o    <= 1'b0;
                ex_pc_o       <= '0;
                ex_rs1_o      <= '0;
                ex_rs2_o      <= '0;
                ex_rd_o       <= '0;
                ex_rs1_data_o <= '0;
                ex_rs2_data_o <= '0;
                ex_imm_o      <= '0;
                ex_ctrl_o     <= BUBBLE_CTRL;
            end else begin
                ex_valid_o    <= id_valid_i;
                ex_pc_o       <= id_pc_i;
                ex_rs1_o      <= id_rs1_i;
                ex_rs2_o      <= id_rs2_i;
                ex_rd_o       <= id_rd_i;
                ex_rs1_data_o <= id_rs1_data_i;
                ex_rs2_data_o <= id_rs2_data_i;
                ex_imm_o      <= id_imm_i;
                ex_ctrl_o     <= id_ctrl_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (!hold_i && stall_o && !cnt_full) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reference model plus literal spot checks.
module tb_id_ex_stage;
    import riscv_pipe_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold = 1'b0;
    logic flush = 1'b0;
    logic id_valid = 1'b0;
    logic [XLEN-1:0] id_pc = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic u1 = 1'b0, u2 = 1'b0;
    logic [XLEN-1:0] id_d1 = '0, id_d2 = '0, id_imm = '0;
    logic [EX_CTRL_W-1:0] id_ctrl = '0;
    logic [4:0] mem_rd = '0;
    logic mem_we = 1'b0;

    logic stall;
    logic ex_valid;
    logic [XLEN-1:0] ex_pc, ex_d1, ex_d2, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [EX_CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0] cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold), .flush_i(flush),
        .id_valid_i(id_valid), .id_pc_i(id_pc),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_rs1_used_i(u1), .id_rs2_used_i(u2),
        .id_rs1_data_i(id_d1), .id_rs2_data_i(id_d2),
        .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
        .ex_mem_rd_i(mem_rd), .ex_mem_reg_write_i(mem_we),
        .stall_o(stall), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc),
        .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd),
        .ex_rs1_data_o(ex_d1), .ex_rs2_data_o(ex_d2),
        .ex_imm_o(ex_imm), .ex_ctrl_o(ex_ctrl), .stall_cnt_o(cnt)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: what EX should hold, as plain variables
    bit m_valid;
    logic [XLEN-1:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0] m_rs1, m_rs2, m_rd;
    logic [EX_CTRL_W-1:0] m_ctrl;
    int m_cnt;
    bit m_h;

    function automatic bit needs(input logic [4:0] r);
        if (r == 0) return 1'b0;
        return (u1 && id_rs1 == r) || (u2 && id_rs2 == r);
    endfunction

    function automatic bit m_hz();
        bit from_ex;
        bit from_mem;
        from_ex  = m_valid && m_ctrl[CTRL_REG_WRITE] && needs(m_rd);
        from_mem = mem_we && needs(mem_rd);
        return id_valid && (from_ex || from_mem);
    endfunction

    task automatic m_clear();
        m_valid = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear();
            m_cnt = 0;
        end else if (!hold) begin
            m_h = m_hz();
            if (flush || m_h) begin
                m_clear();
            end else begin
                m_valid = id_valid; m_pc = id_pc;
                m_d1 = id_d1; m_d2 = id_d2; m_imm = id_imm;
                m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
                m_ctrl = id_ctrl;
            end
            if (m_h && !flush && m_cnt < CMAX) m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("stall", stall, m_hz() && !flush);
            check("valid", ex_valid, m_valid);
            check("pc", ex_pc, m_pc);
            check("rs1", ex_rs1, m_rs1);
            check("rs2", ex_rs2, m_rs2);
            check("rd", ex_rd, m_rd);
            check("d1", ex_d1, m_d1);
            check("d2", ex_d2, m_d2);
            check("imm", ex_imm, m_imm);
            check("ctrl", ex_ctrl, m_ctrl);
            check("cnt", cnt, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1,
                          input logic a1, input logic [4:0] r2,
                          input logic a2, input logic [4:0] rd,
                          input logic wr);
        id_pc    = id_pc + 32'd4;
        id_valid = v;
        id_rs1   = r1; u1 = a1;
        id_rs2   = r2; u2 = a2;
        id_rd    = rd;
        id_d1    = id_pc ^ 32'h1111_0000;
        id_d2    = ~id_pc;
        id_imm   = id_pc << 3;
        id_ctrl  = {wr, id_pc[12:2]};
    endtask

    task automatic set_mem(input logic [4:0] rd, input logic we);
        mem_rd = rd;
        mem_we = we;
    endtask

    initial begin
        #3;
        check("rst_valid", ex_valid, 0);
        check("rst_cnt", cnt, 0);
        check("rst_stall", stall, 0);
        #9 rst_n = 1'b1;
        tick();

        // Latency and asynchronous reset
        set_id(1, 1, 1, 2, 1, 7, 1);
        tick();
        check("lat_valid", ex_valid, 1);
        check("lat_rd", ex_rd, 7);
        set_id(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", ex_valid, 0);
        check("arst_rd", ex_rd, 0);
        check("arst_pc", ex_pc, 0);
        check("arst_ctrl", ex_ctrl, 0);
        #1 rst_n = 1'b1;
        tick();

        // add x5,x1,x2 ; add x6,x5,x3
        set_id(1, 1, 1, 2, 1, 5, 1);
        tick();
        set_id(1, 5, 1, 3, 1, 6, 1);
        #1 check("d1_stall_a", stall, 1);
        tick();
        check("d1_bub_a", ex_valid, 0);
        check("d1_cnt_a", cnt, 1);
        set_mem(5, 1);
        #1 check("d1_stall_b", stall, 1);
        tick();
        check("d1_bub_b", ex_valid, 0);
        set_mem(0, 0);
        #1 check("d1_stall_c", stall, 0);
        tick();
        check("d1_valid", ex_valid, 1);
        check("d1_rs1", ex_rs1, 5);
        check("d1_cnt", cnt, 2);

        // Producer only in EX/MEM
        set_id(1, 9, 1, 0, 0, 10, 1);
        set_mem(9, 1);
        #1 check("d2_stall", stall, 1);
        tick();
        check("d2_cnt", cnt, 3);
        set_mem(0, 0);
        #1 check("d2_stall_end", stall, 0);
        tick();
        check("d2_rs1", ex_rs1, 9);

        // Producer writing x0
        set_id(1, 3, 1, 4, 1, 0, 1);
        tick();
        set_id(1, 0, 1, 0, 1, 12, 1);
        set_mem(0, 1);
        #1 check("x0_stall", stall, 0);
        tick();
        set_mem(0, 0);

        // Unused rs2 (lui) against EX rd=5
        set_id(1, 0, 0, 0, 0, 5, 1);
        tick();
        set_id(1, 0, 0, 5, 0, 13, 1);
        #1 check("lui_stall", stall, 0);

        // Flush coinciding with a hazard
        set_id(1, 5, 1, 0, 0, 14, 1);
        flush = 1'b1;
        #1 check("fl_stall", stall, 0);
        tick();
        flush = 1'b0;
        check("fl_valid", ex_valid, 0);
        check("fl_ctrl", ex_ctrl, 0);
        check("fl_cnt", cnt, 3);
        #1 check("bub_stall", stall, 0);
        tick();

        // Hold with a hazard pending
        set_id(1, 0, 0, 0, 0, 8, 1);
        tick();
        set_id(1, 1, 1, 8, 1, 15, 1);
        hold = 1'b1;
        #1 check("hold_stall", stall, 1);
        repeat (3) tick();
        check("hold_rd", ex_rd, 8);
        check("hold_valid", ex_valid, 1);
        check("hold_cnt", cnt, 3);
        hold = 1'b0;
        tick();
        check("rel_valid", ex_valid, 0);
        check("rel_cnt", cnt, 4);
        set_mem(8, 1);
        tick();
        check("rel_cnt2", cnt, 5);
        set_mem(0, 0);
        tick();
        check("rel_rd", ex_rd, 15);

        // Saturation of the stall counter
        set_id(1, 8, 1, 0, 0, 16, 1);
        set_mem(8, 1);
        repeat (4) tick();
        check("sat_cnt", cnt, CMAX);
        check("sat_stall", stall, 1);
        set_mem(0, 0);
        set_id(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
